wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameters: none; data width is fixed at 32 bits and register index width at 5 bits.
REQ-002 clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream result valid.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_is_load  input  1  1 = load (data comes from memory), 0 = ALU result.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_result  input  32  ALU result, used when in_is_load=0.
REQ-009 in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 in_addr_lo  input  2  byte offset of the load address.
REQ-011 mem_rvalid  input  1  memory read data valid, single-cycle pulse.
REQ-012 mem_rdata  input  32  memory read word, naturally aligned.
REQ-013 rd  output  5  register file write index.
REQ-014 we  output  1  register file write enable.
REQ-015 indata  output  32  register file write data.
REQ-016 load_err  output  1  one-cycle pulse on a misaligned or illegal load.
REQ-017 fwd_valid / fwd_rd / fwd_data  output  1/5/32  forwarding copy of the pending write (see REQ-034).

Function
REQ-018 FSM states: IDLE, WAIT_MEM and WRITE.
REQ-019 in_ready SHALL be 1 in IDLE and WRITE, and 0 in WAIT_MEM.
REQ-020 A transfer occurs when in_valid and in_ready are both 1.
REQ-021 ALU transfer in cycle N: rd, indata and we=1 SHALL be registered so that they are visible in cycle N+1 for exactly one cycle (state WRITE).
REQ-022 Load transfer in cycle N: the stage SHALL latch in_rd, in_funct3 and in_addr_lo and enter WAIT_MEM.
REQ-023 In WAIT_MEM, on the cycle mem_rvalid=1 the aligned data SHALL be registered, and we=1 SHALL follow in the next cycle (WRITE).
REQ-024 Alignment: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16]; LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
REQ-025 A load is misaligned when it is LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0; funct3 values 011, 110 and 111 are illegal.
REQ-026 A misaligned or illegal load SHALL NOT enter WAIT_MEM; it SHALL pulse load_err in cycle N+1, leave we=0, and return to IDLE.
REQ-027 rd=0: the transfer SHALL proceed normally but we SHALL be forced to 0.
REQ-028 WRITE with a new transfer in the same cycle: back-to-back handling, so the next write appears in the following cycle without a bubble.
REQ-029 WRITE with no transfer: return to IDLE; we SHALL drop to 0.
REQ-030 mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-031 we SHALL never be asserted for more than one cycle per accepted transfer.

Reset
REQ-032 While rst_n=0: state=IDLE, we=0, rd=0, indata=0, load_err=0, fwd_valid=0, fwd_rd=0, fwd_data=0; in_ready is 1 from the first cycle after release.
REQ-033 Reset asserted in WAIT_MEM SHALL discard the pending load; a later mem_rvalid SHALL produce no write.

Configuration
REQ-034 Macro WB_STAGE_FWD_EN.
- Defined: fwd_valid, fwd_rd and fwd_data SHALL mirror we, rd and indata in the same cycle, except that fwd_valid=0 when rd=0.
- Not defined: fwd_valid, fwd_rd and fwd_data SHALL be tied to 0 and no forwarding logic is generated.

Structure
REQ-035 Package wb_pkg SHALL hold:
- the state enum (IDLE, WAIT_MEM, WRITE);
- the funct3 load constants (LB, LH, LW, LBU, LHU);
- the XLEN=32 and REG_AW=5 constants.
REQ-036 Alignment and extension (REQ-024) SHALL sit in a combinational sub-module, load_align, with inputs funct3, addr_lo and word and outputs data and err.

Verification
REQ-037 ALU: in_result=0x1234ABCD, rd=5, transfer at cycle 0 -> cycle 1 shows we=1, rd=5, indata=0x1234ABCD; cycle 2 shows we=0.
REQ-038 LB: addr_lo=2, mem_rdata=0x0080FF00, mem_rvalid 3 cycles after the transfer -> indata=0xFFFFFF80 one cycle after mem_rvalid; in_ready=0 throughout WAIT_MEM.
REQ-039 LHU: addr_lo=2, mem_rdata=0x8001_0000 -> indata=0x00008001. LW with addr_lo=1 -> load_err pulses, no write, no wait for memory.
REQ-040 Three back-to-back ALU transfers to rd=1, 2, 3 -> three consecutive we=1 cycles in order; a transfer with rd=0 produces we=0.
REQ-041 Reset pulled low in WAIT_MEM, then mem_rvalid=1 after release -> no we; the next ALU transfer completes normally.
REQ-042 With WB_STAGE_FWD_EN defined, fwd_* equal the write outputs cycle for cycle; without it, fwd_* stay 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/half/word out of an aligned
// memory word, sign- or zero-extends it, and flags misaligned/illegal loads.
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word[8*addr_lo +: 8];
        halfSel = addr_lo[1] ? word[31:16] : word[15:0];
        data    = '0;
        err     = 1'b0;
        case (funct3)
            LB: data = {{24{byteSel[7]}}, byteSel};
            LH: begin
                data = {{16{halfSel[15]}}, halfSel};
                err  = addr_lo[0];
            end
            LW: begin
                data = word;
                err  = (addr_lo != 2'b00);
            end
            LBU: data = {24'd0, byteSel};
            LHU: begin
                data = {16'd0, halfSel};
                err  = addr_lo[0];
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results or aligned load data into a one-cycle
// register-file write. Optional forwarding copy enabled by WB_STAGE_FWD_EN.
module wb_stage
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_result,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [REG_AW-1:0] rd,
    output logic              we,
    output logic [XLEN-1:0]   indata,
    output logic              load_err,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
);

    state_e            state_q, state_d;
    logic [REG_AW-1:0] pendRd_q, pendRd_d;
    logic [2:0]        pendF3_q, pendF3_d;
    logic [1:0]        pendLo_q, pendLo_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   indata_q, indata_d;
    logic              we_q, we_d;
    logic              loadErr_q, loadErr_d;

    logic              waiting;
    logic              xfer;
    logic [2:0]        alignF3;
    logic [1:0]        alignLo;
    logic [XLEN-1:0]   alignData;
    logic              alignErr;

    assign waiting = (state_q == WAIT_MEM);
    assign xfer    = in_valid && in_ready;

    // Outside WAIT_MEM the aligner checks the incoming load; inside it formats the memory word.
    assign alignF3 = waiting ? pendF3_q : in_funct3;
    assign alignLo = waiting ? pendLo_q : in_addr_lo;

    load_align u_align (
        .funct3  (alignF3),
        .addr_lo (alignLo),
        .word    (mem_rdata),
        .data    (alignData),
        .err     (alignErr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = WRITE;
                end
            end
            default: begin
                if (!xfer) begin
                    state_d = IDLE;
                end else if (!in_is_load) begin
                    state_d = WRITE;
                end else if (alignErr) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_MEM;
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = !waiting;
        rd_d      = rd_q;
        indata_d  = indata_q;
        we_d      = 1'b0;
        loadErr_d = 1'b0;
        pendRd_d  = pendRd_q;
        pendF3_d  = pendF3_q;
        pendLo_d  = pendLo_q;
        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    rd_d     = pendRd_q;
                    indata_d = alignData;
                    we_d     = (pendRd_q != '0);
                end
            end
            default: begin
                if (xfer) begin
                    if (!in_is_load) begin
                        rd_d     = in_rd;
                        indata_d = in_result;
                        we_d     = (in_rd != '0);
                    end else if (alignErr) begin
                        loadErr_d = 1'b1;
                    end else begin
                        pendRd_d = in_rd;
                        pendF3_d = in_funct3;
                        pendLo_d = in_addr_lo;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            indata_q  <= '0;
            we_q      <= 1'b0;
            loadErr_q <= 1'b0;
            pendRd_q  <= '0;
            pendF3_q  <= '0;
            pendLo_q  <= '0;
        end else begin
            rd_q      <= rd_d;
            indata_q  <= indata_d;
            we_q      <= we_d;
            loadErr_q <= loadErr_d;
            pendRd_q  <= pendRd_d;
            pendF3_q  <= pendF3_d;
            pendLo_q  <= pendLo_d;
        end
    end

    assign rd       = rd_q;
    assign indata   = indata_q;
    assign we       = we_q;
    assign load_err = loadErr_q;

`ifdef WB_STAGE_FWD_EN
    assign fwd_valid = we_q && (rd_q != '0);
    assign fwd_rd    = rd_q;
    assign fwd_data  = indata_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: drivers push expected writes/errors, a
// negedge monitor pops and compares whenever we or load_err is raised.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_is_load;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] indata;
    logic        load_err;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t expQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_load (in_is_load),
        .in_rd      (in_rd),
        .in_result  (in_result),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rd         (rd),
        .we         (we),
        .indata     (indata),
        .load_err   (load_err),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write or error pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (we === 1'b1 || load_err === 1'b1)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_event", {we, load_err, rd}, 32'h0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("event_cycle", cyc, e.cyc);
                checkOutput("we", {31'd0, we}, {31'd0, !e.err});
                checkOutput("load_err", {31'd0, load_err}, {31'd0, e.err});
                if (!e.err) begin
                    checkOutput("rd", {27'd0, rd}, {27'd0, e.rd});
                    checkOutput("indata", indata, e.data);
                end
            end
        end
    end

    // Forwarding port follows the write port every cycle, or stays zero.
    always @(negedge clk) begin
`ifdef WB_STAGE_FWD_EN
        checkOutput("fwd_valid", {31'd0, fwd_valid}, {31'd0, we && (rd != 5'd0)});
        checkOutput("fwd_rd", {27'd0, fwd_rd}, {27'd0, rd});
        checkOutput("fwd_data", fwd_data, indata);
`else
        checkOutput("fwd_zero", {26'd0, fwd_valid, fwd_rd} | fwd_data, 32'h0);
`endif
    end

    task automatic applyAlu(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = r;
        in_result  = d;
        if (r != 5'd0) begin
            e.cyc = cyc + 1; e.rd = r; e.data = d; e.err = 1'b0;
            expQ.push_back(e);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic applyLoadErr(input logic [2:0] f3, input logic [1:0] lo);
        exp_t e;
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd9;
        in_funct3  = f3;
        in_addr_lo = lo;
        e.cyc = cyc + 1; e.rd = 5'd0; e.data = 32'h0; e.err = 1'b1;
        expQ.push_back(e);
        step();
        in_valid = 1'b0;
        checkOutput("ready_after_err", {31'd0, in_ready}, 32'd1);
    endtask

    // Load with memory response three cycles after the transfer.
    task automatic applyStimulus(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo,
                                 input logic [31:0] word, input logic [31:0] expData);
        exp_t e;
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = r;
        in_funct3  = f3;
        in_addr_lo = lo;
        step();
        in_valid = 1'b0;
        checkOutput("ready_wait0", {31'd0, in_ready}, 32'd0);
        step();
        checkOutput("ready_wait1", {31'd0, in_ready}, 32'd0);
        step();
        checkOutput("ready_wait2", {31'd0, in_ready}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        e.cyc = cyc + 1; e.rd = r; e.data = expData; e.err = 1'b0;
        expQ.push_back(e);
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_0000;
        checkOutput("ready_write", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_is_load = 1'b0; in_rd = '0; in_result = '0;
        in_funct3 = '0; in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        step();
        checkOutput("reset_we", {31'd0, we}, 32'd0);
        checkOutput("reset_rd", {27'd0, rd}, 32'd0);
        checkOutput("reset_indata", indata, 32'd0);
        checkOutput("reset_load_err", {31'd0, load_err}, 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);

        applyAlu(5'd5, 32'h1234ABCD);
        step();
        applyStimulus(5'd6, 3'b000, 2'd2, 32'h0080FF00, 32'hFFFFFF80);
        step();
        applyStimulus(5'd7, 3'b101, 2'd2, 32'h80010000, 32'h00008001);
        applyStimulus(5'd8, 3'b001, 2'd0, 32'h1234F00D, 32'hFFFFF00D);
        applyStimulus(5'd10, 3'b100, 2'd3, 32'hAB000000, 32'h000000AB);
        applyStimulus(5'd11, 3'b010, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        step();
        applyLoadErr(3'b010, 2'd1);
        applyLoadErr(3'b001, 2'd1);
        applyLoadErr(3'b011, 2'd0);
        step();

        applyAlu(5'd1, 32'h11111111);
        applyAlu(5'd2, 32'h22222222);
        applyAlu(5'd3, 32'h33333333);
        applyAlu(5'd0, 32'hFFFFFFFF);
        step();
        step();

        // Reset during WAIT_MEM must drop the pending load.
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd12; in_funct3 = 3'b010; in_addr_lo = 2'd0;
        step();
        in_valid = 1'b0;
        checkOutput("ready_pre_reset", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_we", {31'd0, we}, 32'd0);
        checkOutput("midreset_indata", indata, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("ready_post_reset", {31'd0, in_ready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        step();
        applyAlu(5'd13, 32'h0BADC0DE);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
        step();
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
